// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register feeding the ALU.
// It registers the decoded operands and control bits from ID, then forwards
// results from EX/MEM and MEM/WB into the ALU operands. It also detects
// load-use hazards, requests an IF/ID freeze and inserts a bubble into EX.
// Optional feature: define EX_STALL_CNT_EN to add a saturating 32-bit count
// of inserted hazard bubbles on stall_cnt_o.
module ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [RA_W-1:0]   id_rs1_i,
  input  logic [RA_W-1:0]   id_rs2_i,
  input  logic [RA_W-1:0]   id_rd_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic              id_alusrc_i,
  input  logic [CTRL_W-1:0] id_aluctrl_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_memwrite_i,
  input  logic              exmem_regwrite_i,
  input  logic [RA_W-1:0]   exmem_rd_i,
  input  logic [XLEN-1:0]   exmem_data_i,
  input  logic              memwb_regwrite_i,
  input  logic [RA_W-1:0]   memwb_rd_i,
  input  logic [XLEN-1:0]   memwb_data_i,
  output logic [XLEN-1:0]   data1_o,
  output logic [XLEN-1:0]   data2_o,
  output logic [CTRL_W-1:0] aluctrl_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [RA_W-1:0]   rd_o,
  output logic              regwrite_o,
  output logic              memread_o,
  output logic              memwrite_o,
  output logic              valid_o,
  output logic              hazard_stall_o
`ifdef EX_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  logic              r_valid;
  logic [RA_W-1:0]   r_rs1;
  logic [RA_W-1:0]   r_rs2;
  logic [RA_W-1:0]   r_rd;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic              r_alusrc;
  logic [CTRL_W-1:0] r_aluctrl;
  logic              r_regwrite;
  logic              r_memread;
  logic              r_memwrite;

  logic              w_hazard;
  logic              w_bubble;
  logic [XLEN-1:0]   w_fwd1;
  logic [XLEN-1:0]   w_fwd2;

  // A load in EX whose destination is needed by the instruction in ID must wait one cycle.
  // rs2 only counts when it is really used as a register operand (alusrc=0).
  assign w_hazard = id_valid_i & r_valid & r_memread & (r_rd != '0) &
                    ((r_rd == id_rs1_i) | ((r_rd == id_rs2_i) & ~id_alusrc_i));

  // A flush always kills the incoming instruction, even while held.
  // A hazard bubble only goes in when the pipe is not frozen.
  assign w_bubble = flush_i | (~stall_i & w_hazard);

  // Pipeline register: a bubble clears every field, so EX holds a clean no-op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || (w_bubble)) begin
      if (rst_i || w_bubble) begin
        r_valid    <= 1'b0;
        r_rs1      <= '0;
        r_rs2      <= '0;
        r_rd       <= '0;
        r_rs1_data <= '0;
        r_rs2_data <= '0;
        r_imm      <= '0;
        r_alusrc   <= 1'b0;
        r_aluctrl  <= '0;
        r_regwrite <= 1'b0;
        r_memread  <= 1'b0;
        r_memwrite <= 1'b0;
      end
    end else if (!stall_i) begin
      r_valid    <= id_valid_i;
      r_rs1      <= id_rs1_i;
      r_rs2      <= id_rs2_i;
      r_rd       <= id_rd_i;
      r_rs1_data <= id_rs1_data_i;
      r_rs2_data <= id_rs2_data_i;
      r_imm      <= id_imm_i;
      r_alusrc   <= id_alusrc_i;
      r_aluctrl  <= id_aluctrl_i;
      r_regwrite <= id_regwrite_i;
      r_memread  <= id_memread_i;
      r_memwrite <= id_memwrite_i;
    end
  end

  // Operand forwarding: x0 is never forwarded, and the younger EX/MEM result beats MEM/WB.
  always_comb begin
    w_fwd1 = r_rs1_data;
    if (r_rs1 != '0) begin
      if (exmem_regwrite_i && (exmem_rd_i == r_rs1))
        w_fwd1 = exmem_data_i;
      else if (memwb_regwrite_i && (memwb_rd_i == r_rs1))
        w_fwd1 = memwb_data_i;
    end
    w_fwd2 = r_rs2_data;
    if (r_rs2 != '0) begin
      if (exmem_regwrite_i && (exmem_rd_i == r_rs2))
        w_fwd2 = exmem_data_i;
      else if (memwb_regwrite_i && (memwb_rd_i == r_rs2))
        w_fwd2 = memwb_data_i;
    end
  end

  assign data1_o        = w_fwd1;
  assign data2_o        = r_alusrc ? r_imm : w_fwd2;
  assign store_data_o   = w_fwd2;
  assign aluctrl_o      = r_aluctrl;
  assign rd_o           = r_rd;
  assign regwrite_o     = r_regwrite;
  assign memread_o      = r_memread;
  assign memwrite_o     = r_memwrite;
  assign valid_o        = r_valid;
  assign hazard_stall_o = w_hazard;

`ifdef EX_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count inserted hazard bubbles. The count saturates instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_stall_cnt <= '0;
    else if (w_hazard && !stall_i && !flush_i && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: scoreboard bench for ex_operand_stage.
// Stimulus pushes the expected EX contents for each instruction that enters EX.
// A negedge monitor pops one entry for every cycle in which valid_o is high.
module tb_ex_operand_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic        id_alusrc_i;
  logic [2:0]  id_aluctrl_i;
  logic        id_regwrite_i, id_memread_i, id_memwrite_i;
  logic        exmem_regwrite_i, memwb_regwrite_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [31:0] exmem_data_i, memwb_data_i;
  logic [31:0] data1_o, data2_o, store_data_o;
  logic [2:0]  aluctrl_o;
  logic [4:0]  rd_o;
  logic        regwrite_o, memread_o, memwrite_o, valid_o, hazard_stall_o;
`ifdef EX_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  ex_operand_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_alusrc_i(id_alusrc_i), .id_aluctrl_i(id_aluctrl_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .data1_o(data1_o), .data2_o(data2_o), .aluctrl_o(aluctrl_o), .store_data_o(store_data_o),
    .rd_o(rd_o), .regwrite_o(regwrite_o), .memread_o(memread_o), .memwrite_o(memwrite_o),
    .valid_o(valid_o), .hazard_stall_o(hazard_stall_o)
`ifdef EX_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #10 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] d1, d2, st;
    logic [2:0]  ctrl;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, expv);
    end
  endtask

  task automatic push(input logic [31:0] d1, d2, st, input logic [2:0] c,
                      input logic [4:0] rd, input logic rw, mr, mw);
    exp_t e;
    e.d1 = d1; e.d2 = d2; e.st = st; e.ctrl = c; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw;
    q.push_back(e);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, rs2, rd,
                        input logic [31:0] d1, d2, imm, input logic src,
                        input logic [2:0] c, input logic rw, mr, mw);
    id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
    id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm; id_alusrc_i = src;
    id_aluctrl_i = c; id_regwrite_i = rw; id_memread_i = mr; id_memwrite_i = mw;
  endtask

  task automatic id_idle();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] ed,
                         input logic mrw, input logic [4:0] mrd, input logic [31:0] md);
    exmem_regwrite_i = erw; exmem_rd_i = erd; exmem_data_i = ed;
    memwb_regwrite_i = mrw; memwb_rd_i = mrd; memwb_data_i = md;
  endtask

  // Advance one cycle; drive just after the edge with hold/flush/forwarding cleared.
  task automatic step();
    @(posedge clk_i);
    #1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  function automatic logic [127:0] all_outs();
    return {20'd0, data1_o, data2_o, store_data_o, aluctrl_o, rd_o,
            regwrite_o, memread_o, memwrite_o, valid_o, hazard_stall_o};
  endfunction

  // Monitor: each cycle that EX holds a real instruction must match the oldest expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && valid_o) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: actual valid_o=1 rd=%0d required no pending instruction", rd_o);
      end else begin
        e = q.pop_front();
        chk("sb_data1", data1_o, e.d1);
        chk("sb_data2", data2_o, e.d2);
        chk("sb_store", store_data_o, e.st);
        chk("sb_ctrl", {regwrite_o, memread_o, memwrite_o, aluctrl_o, rd_o},
            {e.rw, e.mr, e.mw, e.ctrl, e.rd});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    id_idle();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("reset_outs", all_outs(), 128'd0);
    step();
    step();
    rst_i = 1'b0;

    // Plain add, then a reset applied between edges while it sits in EX.
    set_id(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 0, 3'd2, 1, 0, 0);
    push(32'd5, 32'd7, 32'd7, 3'd2, 5'd3, 1, 0, 0);
    step();
    set_id(1, 5'd1, 5'd2, 5'd4, 32'd9, 32'd9, 32'd0, 0, 3'd2, 1, 0, 0);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("midop_reset_outs", all_outs(), 128'd0);
    step();
    rst_i = 1'b0;
    id_idle();
    #1;
    chk("post_reset_valid", {31'd0, valid_o}, 32'd0);

    // EX/MEM beats MEM/WB on rs1; the immediate selects data2 and rs2 is not forwarded.
    step();
    set_id(1, 5'd3, 5'd6, 5'd7, 32'd0, 32'h66, 32'h100, 1, 3'd1, 1, 0, 0);
    push(32'h10, 32'h100, 32'h66, 3'd1, 5'd7, 1, 0, 0);
    step();
    set_fwd(1, 5'd3, 32'h10, 1, 5'd3, 32'h20);
    // MEM/WB forward on rs2 while EX/MEM targets another register.
    set_id(1, 5'd1, 5'd2, 5'd9, 32'h11, 32'h22, 32'd0, 0, 3'd3, 1, 0, 0);
    push(32'h11, 32'h2222, 32'h2222, 3'd3, 5'd9, 1, 0, 0);
    step();
    set_fwd(1, 5'd9, 32'hAAAA, 1, 5'd2, 32'h2222);
    // Matching addresses without regwrite must not forward.
    set_id(1, 5'd1, 5'd2, 5'd10, 32'h123, 32'h456, 32'd0, 0, 3'd4, 1, 0, 0);
    push(32'h123, 32'h456, 32'h456, 3'd4, 5'd10, 1, 0, 0);
    step();
    set_fwd(0, 5'd1, 32'hDEAD, 0, 5'd2, 32'hBEEF);
    // x0 is never forwarded.
    set_id(1, 5'd0, 5'd0, 5'd11, 32'd0, 32'd0, 32'd0, 0, 3'd5, 1, 0, 1);
    push(32'd0, 32'd0, 32'd0, 3'd5, 5'd11, 1, 0, 1);
    step();
    set_fwd(1, 5'd0, 32'hFF, 1, 5'd0, 32'hEE);
    id_idle();

    // Load-use: lw x5 in EX, dependent add in ID.
    step();
    set_id(1, 5'd1, 5'd0, 5'd5, 32'h1000, 32'd0, 32'd4, 1, 3'd1, 1, 1, 0);
    push(32'h1000, 32'd4, 32'd0, 3'd1, 5'd5, 1, 1, 0);
    step();
    set_id(1, 5'd1, 5'd5, 5'd8, 32'd0, 32'd0, 32'd0, 1, 3'd2, 1, 0, 0);
    #1 chk("hz_rs2_imm", {31'd0, hazard_stall_o}, 32'd0);
    id_alusrc_i = 1'b0;
    #1 chk("hz_rs2_reg", {31'd0, hazard_stall_o}, 32'd1);
    id_valid_i = 1'b0;
    #1 chk("hz_id_invalid", {31'd0, hazard_stall_o}, 32'd0);
    set_id(1, 5'd5, 5'd6, 5'd8, 32'd0, 32'h60, 32'd0, 0, 3'd2, 1, 0, 0);
    #1 chk("hz_rs1", {31'd0, hazard_stall_o}, 32'd1);
    step();
    #1;
    chk("bubble_valid_rw", {30'd0, valid_o, regwrite_o}, 32'd0);
    chk("bubble_fields", {24'd0, aluctrl_o, rd_o, memread_o, memwrite_o}, 32'd0);
    chk("bubble_hz", {31'd0, hazard_stall_o}, 32'd0);
    push(32'h5555, 32'h60, 32'h60, 3'd2, 5'd8, 1, 0, 0);
    step();
    set_fwd(1, 5'd5, 32'h5555, 0, 5'd0, 32'd0);
    id_idle();

    // External hold keeps EX unchanged, then flush together with hold, then flush alone.
    step();
    set_id(1, 5'd1, 5'd2, 5'd12, 32'h77, 32'h88, 32'd0, 0, 3'd6, 1, 0, 0);
    push(32'h77, 32'h88, 32'h88, 3'd6, 5'd12, 1, 0, 0);
    step();
    set_id(1, 5'd3, 5'd4, 5'd13, 32'h99, 32'hAA, 32'd0, 0, 3'd7, 1, 0, 0);
    stall_i = 1'b1;
    push(32'h77, 32'h88, 32'h88, 3'd6, 5'd12, 1, 0, 0);
    step();
    stall_i = 1'b1;
    flush_i = 1'b1;
    step();
    #1;
    chk("flush_stall_bubble", {24'd0, valid_o, regwrite_o, rd_o, memwrite_o}, 32'd0);
    flush_i = 1'b1;
    step();
    #1;
    chk("flush_bubble", {30'd0, valid_o, regwrite_o}, 32'd0);
    id_idle();

    // Three load-use hazards after a fresh reset; the middle one sees a hold on its edge.
    step();
    rst_i = 1'b1;
    exp_cnt = 0;
    #1 chk("t6_reset_outs", all_outs(), 128'd0);
    step();
    rst_i = 1'b0;
`ifdef EX_STALL_CNT_EN
    chk("cnt_reset", stall_cnt_o, 32'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      step();
      set_id(1, 5'd1, 5'd0, 5'd5, 32'h2000 + k, 32'd0, 32'd0, 1, 3'd1, 1, 1, 0);
      push(32'h2000 + k, 32'd0, 32'd0, 3'd1, 5'd5, 1, 1, 0);
      step();
      set_id(1, 5'd5, 5'd0, 5'd8, 32'd0, 32'd0, 32'd0, 0, 3'd2, 1, 0, 0);
      #1 chk("t6_hz", {31'd0, hazard_stall_o}, 32'd1);
      if (k == 1) begin
        stall_i = 1'b1;
        push(32'h2000 + k, 32'd0, 32'd0, 3'd1, 5'd5, 1, 1, 0);
        step();
        id_idle();
      end else begin
        exp_cnt++;
        step();
        push(32'd0, 32'd0, 32'd0, 3'd2, 5'd8, 1, 0, 0);
        step();
        id_idle();
      end
    end
    step();
    step();
`ifdef EX_STALL_CNT_EN
    chk("stall_cnt", stall_cnt_o, exp_cnt);
`endif
    chk("sb_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
